// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt collector: source limit, width helper
// and the clear-handshake state type.
package irq_pkg;

   localparam int IRQ_MAX_SRC = 16;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_HOLD = 1'b1
   } clr_state_e;

   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit encoder: index of the least significant 1 plus
// a valid flag. The index is 0 when no bit is set.
module prio_enc_lsb
   import irq_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = clog2_f(N)
) (
   input  logic [N-1:0]   i_vec,
   output logic [IDW-1:0] o_idx,
   output logic           o_valid
);

   localparam int NW = (N < IRQ_MAX_SRC) ? N : IRQ_MAX_SRC;

   always_comb begin
      o_idx   = '0;
      o_valid = |i_vec;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = NW - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/irq_or_collector.sv
// Sticky event collector with per-source mask, registered OR-reduced irq and
// lowest-index irq_id, plus a clear port that needs one idle cycle between clears.
module irq_or_collector
   import irq_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int EDGE  = 1,
   parameter int IDW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] src,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_in,
   input  logic             clr_valid,
   input  logic [N_SRC-1:0] clr_vec,
   output logic             clr_ready,
   output logic             irq,
   output logic [IDW-1:0]   irq_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] overrun
);

   logic [N_SRC-1:0] r_src_q;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_overrun;
   logic [N_SRC-1:0] r_mask;
   logic             r_irq;
   logic [IDW-1:0]   r_irq_id;
   clr_state_e       r_clr_state;

   clr_state_e       w_clr_state_next;
   logic [N_SRC-1:0] w_ev;
   logic [N_SRC-1:0] w_pending_next;
   logic [N_SRC-1:0] w_overrun_next;
   logic [N_SRC-1:0] w_masked;
   logic [IDW-1:0]   w_enc_idx;
   logic             w_enc_valid;
   logic             w_clr_acc;

   // The source history is kept through reset so a line held high across
   // reset release is not seen as a fresh edge.
   always_ff @(posedge clk) begin
      r_src_q <= src;
   end

   generate
      if (EDGE != 0) begin : g_edge
         assign w_ev = src & ~r_src_q;
      end else begin : g_level
         assign w_ev = src;
      end
   endgenerate

   assign w_clr_acc = clr_valid & clr_ready;

   // An event beats a simultaneous clear so nothing is lost; overrun only
   // records an event landing on an already pending bit.
   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_bit
         always_comb begin
            w_pending_next[gi] = r_pending[gi];
            w_overrun_next[gi] = r_overrun[gi];
            if (w_ev[gi]) begin
               w_pending_next[gi] = 1'b1;
               w_overrun_next[gi] = r_overrun[gi] | r_pending[gi];
            end else if (w_clr_acc && clr_vec[gi]) begin
               w_pending_next[gi] = 1'b0;
               w_overrun_next[gi] = 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_overrun <= '0;
         r_mask    <= '0;
      end else begin
         r_pending <= w_pending_next;
         r_overrun <= w_overrun_next;
         if (mask_we) begin
            r_mask <= mask_in;
         end
      end
   end

   assign w_masked = r_pending & r_mask;

   prio_enc_lsb #(
      .N   (N_SRC),
      .IDW (IDW)
   ) u_prio (
      .i_vec   (w_masked),
      .o_idx   (w_enc_idx),
      .o_valid (w_enc_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_irq    <= 1'b0;
         r_irq_id <= '0;
      end else begin
         r_irq    <= w_enc_valid;
         r_irq_id <= w_enc_idx;
      end
   end

   // Reset parks the handshake in CLR_HOLD so clr_ready stays low until the
   // first clock after reset release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_clr_state <= CLR_HOLD;
      end else begin
         r_clr_state <= w_clr_state_next;
      end
   end

   always_comb begin
      w_clr_state_next = r_clr_state;
      case (r_clr_state)
         CLR_IDLE: if (clr_valid) w_clr_state_next = CLR_HOLD;
         CLR_HOLD: w_clr_state_next = CLR_IDLE;
         default:  w_clr_state_next = CLR_IDLE;
      endcase
   end

   always_comb begin
      clr_ready = (r_clr_state == CLR_IDLE);
   end

   assign irq     = r_irq;
   assign irq_id  = r_irq_id;
   assign pending = r_pending;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_irq_or_collector.sv
// Self-checking bench: directed vector table, hand sequences for reset and
// clear spacing, then random traffic against a cycle-level behavioural model.
module tb_irq_or_collector;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] src;
   logic         mask_we;
   logic [N-1:0] mask_in;
   logic         clr_valid;
   logic [N-1:0] clr_vec;
   logic         clr_ready;
   logic         irq;
   logic [1:0]   irq_id;
   logic [N-1:0] pending;
   logic [N-1:0] overrun;

   int vectors    = 0;
   int miscompares = 0;

   // model state
   logic [N-1:0] m_pend, m_ovr, m_mask, m_prev;
   logic         m_irq, m_rdy;
   logic [1:0]   m_id;

   typedef struct {
      logic [N-1:0] src;
      logic         mwe;
      logic [N-1:0] min;
      logic         cv;
      logic [N-1:0] cvec;
      logic [N-1:0] pend;
      logic [N-1:0] ovr;
      logic         irq;
      logic [1:0]   id;
      logic         rdy;
   } vec_t;

   vec_t tbl [16];

   irq_or_collector #(.N_SRC(N), .EDGE(1), .IDW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src       (src),
      .mask_we   (mask_we),
      .mask_in   (mask_in),
      .clr_valid (clr_valid),
      .clr_vec   (clr_vec),
      .clr_ready (clr_ready),
      .irq       (irq),
      .irq_id    (irq_id),
      .pending   (pending),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] lowest(input logic [N-1:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the reference behaviour, using the inputs present at the edge.
   task automatic model_edge();
      logic [N-1:0] ev;
      logic         acc;
      if (!rst_n) begin
         m_pend = '0; m_ovr = '0; m_mask = '0;
         m_irq = 1'b0; m_id = 2'd0; m_rdy = 1'b0;
      end else begin
         acc   = clr_valid && m_rdy;
         m_irq = (m_pend & m_mask) != '0;
         m_id  = lowest(m_pend & m_mask);
         ev    = src & ~m_prev;
         for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
               if (m_pend[i]) m_ovr[i] = 1'b1;
               m_pend[i] = 1'b1;
            end else if (acc && clr_vec[i]) begin
               m_pend[i] = 1'b0;
               m_ovr[i]  = 1'b0;
            end
         end
         if (mask_we) m_mask = mask_in;
         m_rdy = !acc;
      end
      m_prev = src;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_pending", 32'(pending), 32'(m_pend));
      chk("model_overrun", 32'(overrun), 32'(m_ovr));
      chk("model_irq", 32'(irq), 32'(m_irq));
      chk("model_irq_id", 32'(irq_id), 32'(m_id));
      chk("model_clr_ready", 32'(clr_ready), 32'(m_rdy));
   endtask

   initial begin
      rst_n = 1'b0; src = 4'b0011; mask_we = 1'b0; mask_in = '0;
      clr_valid = 1'b0; clr_vec = '0;
      m_prev = '0;

      // Reset with two sources held high.
      repeat (3) cyc();
      chk("reset_pending", 32'(pending), 32'h0);
      chk("reset_irq", 32'(irq), 32'h0);
      chk("reset_clr_ready", 32'(clr_ready), 32'h0);

      rst_n = 1'b1; mask_we = 1'b1; mask_in = 4'hF;
      for (int k = 0; k < 5; k++) begin
         cyc();
         mask_we = 1'b0;
         chk("held_src_pending", 32'(pending), 32'h0);
         chk("held_src_irq", 32'(irq), 32'h0);
      end

      tbl[0]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[1]  = '{4'b0100, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[2]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1};
      tbl[3]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1};
      tbl[4]  = '{4'b0000, 1'b0, 4'h0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0};
      tbl[5]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b0, 4'h0, 4'b1010, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[7]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b1010, 4'b0000, 1'b1, 2'd3, 1'b1};
      tbl[8]  = '{4'b0000, 1'b0, 4'h0, 1'b1, 4'b1000, 4'b0010, 4'b0000, 1'b1, 2'd3, 1'b0};
      tbl[9]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[10] = '{4'b0010, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0010, 4'b0010, 1'b0, 2'd0, 1'b1};
      tbl[11] = '{4'b0000, 1'b0, 4'h0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[12] = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[13] = '{4'b0001, 1'b0, 4'h0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[14] = '{4'b0000, 1'b1, 4'hF, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[15] = '{4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1};

      for (int r = 0; r < 16; r++) begin
         src = tbl[r].src; mask_we = tbl[r].mwe; mask_in = tbl[r].min;
         clr_valid = tbl[r].cv; clr_vec = tbl[r].cvec;
         cyc();
         chk($sformatf("tbl%0d_pending", r), 32'(pending), 32'(tbl[r].pend));
         chk($sformatf("tbl%0d_overrun", r), 32'(overrun), 32'(tbl[r].ovr));
         chk($sformatf("tbl%0d_irq", r), 32'(irq), 32'(tbl[r].irq));
         chk($sformatf("tbl%0d_irq_id", r), 32'(irq_id), 32'(tbl[r].id));
         chk($sformatf("tbl%0d_clr_ready", r), 32'(clr_ready), 32'(tbl[r].rdy));
      end
      mask_we = 1'b0; clr_valid = 1'b0;

      // Held clear request: accepted, ignored while not ready, then accepted.
      src = 4'b0110; cyc();
      src = 4'b0000; cyc();
      chk("b2b_pending_pre", 32'(pending), 32'h7);
      clr_valid = 1'b1; clr_vec = 4'b0001; cyc();
      chk("b2b_first_ready", 32'(clr_ready), 32'h0);
      chk("b2b_first_pending", 32'(pending), 32'h6);
      clr_vec = 4'b0010; cyc();
      chk("b2b_ignored_ready", 32'(clr_ready), 32'h1);
      chk("b2b_ignored_pending", 32'(pending), 32'h6);
      cyc();
      chk("b2b_second_ready", 32'(clr_ready), 32'h0);
      chk("b2b_second_pending", 32'(pending), 32'h4);
      clr_valid = 1'b0; clr_vec = '0;

      // Reset while irq is active.
      cyc();
      chk("pre_rst_irq", 32'(irq), 32'h1);
      chk("pre_rst_irq_id", 32'(irq_id), 32'h2);
      rst_n = 1'b0; cyc();
      chk("midrst_irq", 32'(irq), 32'h0);
      chk("midrst_pending", 32'(pending), 32'h0);
      chk("midrst_overrun", 32'(overrun), 32'h0);
      rst_n = 1'b1; src = 4'b0001; cyc();
      src = 4'b0000; cyc(); cyc();
      chk("midrst_mask_pending", 32'(pending), 32'h1);
      chk("midrst_mask_irq", 32'(irq), 32'h0);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         src       = 4'($urandom);
         mask_we   = ($urandom_range(0, 5) == 0);
         mask_in   = 4'($urandom);
         clr_valid = ($urandom_range(0, 1) == 1);
         clr_vec   = 4'($urandom);
         rst_n     = ($urandom_range(0, 63) != 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
